// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and the {pc, inst} entry type used by the fetch stage.
package fetch_pkg;

    localparam int ADDR_W = 30;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO between the ROM return path and decode.
// The head output is zero while the FIFO is empty.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     push_data,
    output logic [1:0] count,
    output entry_t     head
);

    entry_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: storage is not reset; count and the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch_stage.sv
// MIPS instruction fetch: owns the PC, drives the synchronous ROM, pairs each
// returned word with its PC and hands the pairs to decode through a skid FIFO.
module inst_fetch_stage #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INST_W   = fetch_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              req_valid;
    logic              deq;
    logic              issue;
    logic              push;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    entry_t            push_data;
    entry_t            head;

    // NOTE: every branch assigns imem_addr, so no latch is inferred.
    always_comb begin
        if (!rst_n)
            imem_addr = RESET_PC;
        else if (redirect_valid)
            imem_addr = redirect_pc;
        else
            imem_addr = fetch_pc;
    end

    assign out_valid = (count != 2'd0) && !redirect_valid;
    assign deq       = out_valid && out_ready;

    // Occupancy after this edge if nothing new is issued: only issue while
    // the returning word is guaranteed a free slot.
    assign occupancy = 3'(count) + 3'(req_valid) - 3'(deq);
    assign issue     = redirect_valid || (occupancy < 3'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            req_valid <= 1'b0;
            req_pc    <= '0;
        end else if (issue) begin
            req_valid <= 1'b1;
            req_pc    <= imem_addr;
            fetch_pc  <= imem_addr + ADDR_W'(1);
        end else begin
            req_valid <= 1'b0;
        end
    end

    // A redirect discards the word returning this cycle.
    assign push      = req_valid && !redirect_valid;
    assign push_data = '{pc: req_pc, inst: imem_inst};

    fetch_skid_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (deq),
        .flush     (redirect_valid),
        .push_data (push_data),
        .count     (count),
        .head      (head)
    );

    assign out_inst = head.inst;
    assign out_pc   = head.pc;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: synchronous ROM model, scoreboard of expected
// {pc, inst} handshakes, and directed cycle checks around stalls and redirects.
module tb_inst_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [29:0] out_pc;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    inst_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    // Synchronous ROM: registers the address, reset tied to ~rst_n.
    function automatic logic [31:0] rom_word(input logic [29:0] a);
        case (a)
            30'h00:  return 32'h2409ffff;
            30'h01:  return 32'h40896000;
            30'h02:  return 32'h24170000;
            30'h03:  return 32'h3c1d0000;
            30'h04:  return 32'h27bd1000;
            30'h05:  return 32'h8fa40000;
            30'h06:  return 32'h24050001;
            30'h07:  return 32'h20a50001;
            30'h08:  return 32'h10a0fffe;
            30'h09:  return 32'h00a52021;
            30'h0A:  return 32'h00852023;
            30'h0B:  return 32'h08000000;
            30'h0C:  return 32'h241100fd;
            30'h0D:  return 32'h3c108000;
            30'h0E:  return 32'h36100001;
            30'h0F:  return 32'hac110000;
            default: return 32'h00000000;
        endcase
    endfunction

    logic        rom_rst;
    logic [29:0] rom_addr_q;

    assign rom_rst = ~rst_n;

    always @(posedge clk) begin
        if (rom_rst) rom_addr_q <= '0;
        else         rom_addr_q <= imem_addr;
    end

    assign imem_inst = rom_word(rom_addr_q);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [29:0] pc, input logic [31:0] inst);
        exp_q.push_back('{pc: pc, inst: inst});
    endtask

    // One cycle: wait past the edge, drive inputs, let combinational outputs settle.
    task automatic cyc(input logic rst_v, input logic ready_v, input logic redir_v,
                       input logic [29:0] rpc);
        @(posedge clk);
        #1;
        rst_n          = rst_v;
        out_ready      = ready_v;
        redirect_valid = redir_v;
        redirect_pc    = rpc;
        #2;
    endtask

    // Monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_handshake: got pc %h inst %h, required no transfer",
                         out_pc, out_inst);
            end else begin
                e = exp_q.pop_front();
                check("handshake_pc",   64'(out_pc),   64'(e.pc));
                check("handshake_inst", 64'(out_inst), 64'(e.inst));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 30'h0);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_pc",    64'(out_pc),    64'(0));
        check("rst_out_inst",  64'(out_inst),  64'(0));
        check("rst_imem_addr", 64'(imem_addr), 64'(0));

        // Steady flow from reset release, one instruction per cycle from cycle 2
        push_exp(30'h0, 32'h2409ffff);
        push_exp(30'h1, 32'h40896000);
        push_exp(30'h2, 32'h24170000);
        push_exp(30'h3, 32'h3c1d0000);
        cyc(1'b1, 1'b1, 1'b0, 30'h0);
        check("a_c0_valid", 64'(out_valid), 64'(0));
        check("a_c0_addr",  64'(imem_addr), 64'(0));
        cyc(1'b1, 1'b1, 1'b0, 30'h0);
        check("a_c1_valid", 64'(out_valid), 64'(0));
        check("a_c1_addr",  64'(imem_addr), 64'(1));
        cyc(1'b1, 1'b1, 1'b0, 30'h0);
        check("a_c2_valid", 64'(out_valid), 64'(1));
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 30'h0);

        // Stall until the buffer holds two entries (pc 4, 5)
        cyc(1'b1, 1'b0, 1'b0, 30'h0);
        check("a_stall_addr", 64'(imem_addr), 64'(6));
        cyc(1'b1, 1'b0, 1'b0, 30'h0);
        check("a_full_valid", 64'(out_valid), 64'(1));
        check("a_full_pc",    64'(out_pc),    64'(4));

        // Reset with two entries buffered
        cyc(1'b0, 1'b0, 1'b0, 30'h0);
        check("mid_rst_addr", 64'(imem_addr), 64'(0));

        // Restart, stall from cycle 2 for 5 cycles
        cyc(1'b1, 1'b0, 1'b0, 30'h0);
        check("b_c0_valid", 64'(out_valid), 64'(0));
        check("b_c0_addr",  64'(imem_addr), 64'(0));
        cyc(1'b1, 1'b0, 1'b0, 30'h0);
        check("b_c1_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 30'h0);
            check("b_hold_valid", 64'(out_valid), 64'(1));
            check("b_hold_pc",    64'(out_pc),    64'(0));
            check("b_hold_inst",  64'(out_inst),  64'(32'h2409ffff));
            check("b_hold_addr",  64'(imem_addr), 64'(2));
        end

        // Release: pc 0..4 back to back, then redirect to 0x0C
        push_exp(30'h0, 32'h2409ffff);
        push_exp(30'h1, 32'h40896000);
        push_exp(30'h2, 32'h24170000);
        push_exp(30'h3, 32'h3c1d0000);
        push_exp(30'h4, 32'h27bd1000);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 30'h0);

        cyc(1'b1, 1'b1, 1'b1, 30'h0C);
        check("redir_valid_t0", 64'(out_valid), 64'(0));
        check("redir_addr",     64'(imem_addr), 64'(30'h0C));
        cyc(1'b1, 1'b1, 1'b0, 30'h0);
        check("redir_valid_t1", 64'(out_valid), 64'(0));
        push_exp(30'h0C, 32'h241100fd);
        push_exp(30'h0D, 32'h3c108000);
        cyc(1'b1, 1'b1, 1'b0, 30'h0);
        check("redir_valid_t2", 64'(out_valid), 64'(1));
        cyc(1'b1, 1'b1, 1'b0, 30'h0);

        // Fill while stalled, then redirect to the top word with out_ready high
        cyc(1'b1, 1'b0, 1'b0, 30'h0);
        cyc(1'b1, 1'b0, 1'b0, 30'h0);
        check("full_pc",   64'(out_pc),    64'(30'h0E));
        check("full_addr", 64'(imem_addr), 64'(30'h10));
        cyc(1'b1, 1'b1, 1'b1, 30'h3FFFFFFF);
        check("wrap_redir_valid", 64'(out_valid), 64'(0));
        check("wrap_redir_addr",  64'(imem_addr), 64'(30'h3FFFFFFF));
        push_exp(30'h3FFFFFFF, 32'h00000000);
        push_exp(30'h0, 32'h2409ffff);
        push_exp(30'h1, 32'h40896000);
        cyc(1'b1, 1'b1, 1'b0, 30'h0);
        check("wrap_t1_valid", 64'(out_valid), 64'(0));
        check("wrap_t1_addr",  64'(imem_addr), 64'(0));
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 30'h0);

        // Drain and finish
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 30'h0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_stage.md
# inst_fetch_stage

Instruction fetch stage for the MIPS pipeline. It owns the program counter, drives the word address into the synchronous instruction ROM, which registers the address and returns `inst` one cycle later, and pairs each returned word with its PC. It holds the pairs in a 2-entry skid buffer and hands them to decode over a valid/ready handshake. Decode or execute can redirect the fetch stream on a branch or jump.

## Interface
Parameters:
- `ADDR_W`, 30, word-address width (byte PC bits [31:2]).
- `INST_W`, 32, instruction width.
- `RESET_PC`, 30'h0, first word address fetched after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_addr`  out  ADDR_W  word address to the ROM; the ROM samples it every rising edge.
- `imem_inst`  in  INST_W  ROM data for the address sampled at the previous edge.
- `redirect_valid`  in  1  flush the stage and restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  redirect target (word address).
- `out_valid`  out  1  `out_inst`/`out_pc` are valid.
- `out_ready`  in  1  decode accepts the head entry this cycle.
- `out_inst`  out  INST_W  instruction at the buffer head.
- `out_pc`  out  ADDR_W  word address of `out_inst`.

## Operation
- State:
  - `fetch_pc`: next address to issue.
  - `req_valid`, `req_pc`: one in-flight ROM read.
  - 2-entry FIFO of {pc, inst}.
  - `count` (0..2).
- Reset (`rst_n`=0 at an edge):
  - `fetch_pc`←`RESET_PC`, `req_valid`←0, FIFO emptied.
  - `out_valid`=0, `out_inst`=0, `out_pc`=0.
  - `imem_addr`=`RESET_PC` while in reset.
- `imem_addr` = `redirect_valid ? redirect_pc : fetch_pc` (combinational mux).
- `deq` = `out_valid & out_ready & !redirect_valid`.
- Issue rule:
  - `issue` = `redirect_valid | (count + req_valid − deq < 2)`.
  - On issue: `req_valid`←1, `req_pc`←`imem_addr`, `fetch_pc`←`imem_addr`+1 (mod 2^ADDR_W, wraps to 0).
  - No issue: `req_valid`←0 and `fetch_pc` holds. The ROM re-reads the same address, and the result is ignored.
- Enqueue: if `req_valid` and not `redirect_valid`, push {`req_pc`, `imem_inst`}. The issue rule guarantees space; overflow is impossible.
- Dequeue on `deq`. Simultaneous enqueue and dequeue is legal at any count, and `count` is unchanged.
- Redirect:
  - FIFO cleared and the in-flight read discarded.
  - `out_valid` forced to 0 in the redirect cycle, so no handshake occurs even if `out_ready`=1.
  - `redirect_pc` is issued in the same cycle.
  - Redirect takes priority over every other event.
- Output:
  - `out_valid` = (`count`≠0) & !`redirect_valid`.
  - `out_inst`/`out_pc` come from the FIFO head and are 0 when empty.
  - While `out_valid` & !`out_ready`, the outputs stay stable.

## Timing
- Issue at cycle T → ROM data in T+1 → entry visible at `out_valid` in T+2. Fetch-to-decode latency is 2 cycles.
- First `out_valid` is the 2nd cycle after the first cycle with `rst_n`=1, with `out_pc`=`RESET_PC`.
- Redirect asserted in cycle T → first redirected instruction presented at T+2.
- Steady state with `out_ready`=1: one instruction per cycle with no bubbles.
- Stall release: a held entry is accepted the same cycle `out_ready` rises. The next entry follows the next cycle with no bubble.
- Reset mid-stream discards all buffered and in-flight data on that edge.

## Structure
- Shared package `fetch_pkg`: `ADDR_W`, `INST_W`, `RESET_PC` default, and a `fetch_entry_t` {pc, inst} typedef.
- Sub-module `fetch_skid_fifo`: 2-entry FIFO with push, pop, flush, count, and head outputs.
- The top level holds the PC, in-flight tracking, issue logic and redirect mux.
- Top-level integration ties the ROM reset to `~rst_n`.

## Test plan
- Reset release with `out_ready`=1 against the ROM program → cycle 2 `out_pc`=0/`out_inst`=32'h2409ffff, cycle 3 pc 1/32'h40896000, cycle 4 pc 2/32'h24170000, one per cycle.
- Hold `out_ready`=0 from cycle 2 for 5 cycles:
  - Outputs held at pc 0.
  - `imem_addr` freezes at 2 after the buffer fills.
  - On release: pc 0,1,2,3 on consecutive cycles, none lost or duplicated.
- `redirect_valid`=1, `redirect_pc`=30'h0C in steady flow:
  - `out_valid`=0 in the redirect cycle and the next.
  - Then pc 0C/32'h241100fd, pc 0D/32'h3c108000.
- Redirect while full and stalled, with `out_ready`=1 in the same cycle → no handshake, buffer flushed, target appears 2 cycles later.
- `redirect_pc`=30'h3FFFFFFF → next issued address wraps to 0; instruction 32'h00000000 is delivered for out-of-range words.
- Assert `rst_n`=0 with 2 entries buffered → next cycle `out_valid`=0 and `imem_addr`=`RESET_PC`; the sequence restarts at pc 0.
